// File: rtl/noise_pkg.sv
// Shared widths, constants and LFSR helpers for the four-lane AWGN noise source.
// Each noise sample is S(26,19): a centred S(11,7) byte sum times a U(16,12) sigma.
package noise_pkg;

    localparam int NB_NOISE  = 26;
    localparam int NBF_NOISE = 19;
    localparam int NB_SIGMA  = 16;
    localparam int NB_C      = 11;
    localparam int NB_LFSR   = 32;
    localparam int NB_SUM    = 10;

    // Galois form of x^32 + x^22 + x^2 + x + 1
    localparam logic [NB_LFSR-1:0] LFSR_TAPS = 32'h8020_0003;
    localparam logic [NB_C-1:0]    C_CENTRE  = 11'd510;

    function automatic logic [NB_LFSR-1:0] sanitize_seed(input logic [NB_LFSR-1:0] seed);
        return (seed == '0) ? 32'h0000_0001 : seed;
    endfunction

    // A zero state would lock the LFSR forever, so it is steered back onto the sequence.
    function automatic logic [NB_LFSR-1:0] lfsr_next(input logic [NB_LFSR-1:0] s);
        if (s == '0) begin
            return 32'h0000_0001;
        end
        return (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
    endfunction

endpackage

// File: rtl/awgn_lane.sv
// One noise lane: 32-bit Galois LFSR, four-byte centred sum (stage 1) and sigma scaling
// (stage 2). All registers advance together on enable; reseed wins over enable.
module awgn_lane
    import noise_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                enable_i,
    input  logic                reseed_i,
    input  logic [NB_LFSR-1:0]  seed_i,
    input  logic [NB_SIGMA-1:0] sigma_i,
    output logic [NB_NOISE-1:0] noise_o
);

    logic [NB_LFSR-1:0]        state_q, state_d;
    logic [NB_C-1:0]           c_q, c_d;
    logic [NB_NOISE-1:0]       noise_q, noise_d;
    logic [NB_SUM-1:0]         byte_sum;
    logic [NB_C+NB_SIGMA:0]    product;

    // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        noise_d  = noise_q;

        byte_sum = {2'b00, state_q[7:0]}   + {2'b00, state_q[15:8]}
                 + {2'b00, state_q[23:16]} + {2'b00, state_q[31:24]};

        // Two's-complement c times zero-extended sigma; the low 26 bits are the exact S(26,19) result.
        product  = {{(NB_SIGMA+1){c_q[NB_C-1]}}, c_q} * {{(NB_C+1){1'b0}}, sigma_i};

        if (reseed_i) begin
            state_d = seed_i;
            c_d     = '0;
            noise_d = '0;
        end else if (enable_i) begin
            state_d = lfsr_next(state_q);
            c_d     = {1'b0, byte_sum} - C_CENTRE;
            noise_d = product[NB_NOISE-1:0];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all lanes see pre-edge values.
    // seed_i is a parameter-derived constant, so loading it under async reset is a fixed preset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= seed_i;
            c_q     <= '0;
            noise_q <= '0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            noise_q <= noise_d;
        end
    end

    assign noise_o = noise_q;

endmodule

// File: rtl/awgn_noise_gen.sv
// Four-lane Gaussian noise source for the channel model: four lockstep awgn_lane
// instances plus the two-stage valid pipeline and zero-seed sanitation.
module awgn_noise_gen
    import noise_pkg::*;
#(
    parameter logic [NB_LFSR-1:0] SEED0 = 32'hACE1_0001,
    parameter logic [NB_LFSR-1:0] SEED1 = 32'h1234_5678,
    parameter logic [NB_LFSR-1:0] SEED2 = 32'hDEAD_BEEF,
    parameter logic [NB_LFSR-1:0] SEED3 = 32'h0BAD_F00D
) (
    input  logic                CLK100MHZ,
    input  logic                ck_rst,
    input  logic                i_enable,
    input  logic                i_reseed,
    input  logic [NB_SIGMA-1:0] i_sigma,
    output logic [NB_NOISE-1:0] o_noise1i,
    output logic [NB_NOISE-1:0] o_noise1q,
    output logic [NB_NOISE-1:0] o_noise2i,
    output logic [NB_NOISE-1:0] o_noise2q,
    output logic                o_valid
);

    localparam int NUM_LANES = 4;

    localparam logic [NB_LFSR-1:0] LANE_SEEDS [NUM_LANES] = '{
        sanitize_seed(SEED0), sanitize_seed(SEED1),
        sanitize_seed(SEED2), sanitize_seed(SEED3)
    };

    logic [NB_NOISE-1:0] lane_noise [NUM_LANES];
    logic                v1_q, v1_d;
    logic                valid_q, valid_d;

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        awgn_lane u_lane (
            .clk      (CLK100MHZ),
            .rst      (ck_rst),
            .enable_i (i_enable),
            .reseed_i (i_reseed),
            .seed_i   (LANE_SEEDS[g]),
            .sigma_i  (i_sigma),
            .noise_o  (lane_noise[g])
        );
    end

    // v1 marks stage 1 as loaded; o_valid follows it one enabled edge later, like the data.
    always_comb begin
        v1_d    = v1_q;
        valid_d = valid_q;
        if (i_reseed) begin
            v1_d    = 1'b0;
            valid_d = 1'b0;
        end else if (i_enable) begin
            v1_d    = 1'b1;
            valid_d = v1_q;
        end
    end

    always_ff @(posedge CLK100MHZ or posedge ck_rst) begin
        if (ck_rst) begin
            v1_q    <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            v1_q    <= v1_d;
            valid_q <= valid_d;
        end
    end

    assign o_noise1i = lane_noise[0];
    assign o_noise1q = lane_noise[1];
    assign o_noise2i = lane_noise[2];
    assign o_noise2q = lane_noise[3];
    assign o_valid   = valid_q;

endmodule

// File: tb/tb_awgn_noise_gen.sv
// Self-checking bench for awgn_noise_gen: directed values, randomised enable/reseed/sigma
// traffic against a sample-count reference model, and first/second-moment statistics.
module tb_awgn_noise_gen;

    localparam logic [31:0] S0 = 32'hFFFF_FFFF;
    localparam logic [31:0] S1 = 32'h0000_0001;
    localparam logic [31:0] S2 = 32'h8080_8080;
    localparam logic [31:0] S3 = 32'h0000_0000;
    localparam int          N_STAT = 20000;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        reseed;
    logic [15:0] sigma;
    logic [25:0] n1i, n1q, n2i, n2q;
    logic        valid;

    int total;
    int bad;

    // Reference model: per lane, the LFSR state that the next enabled edge consumes,
    // the centred value of the previously consumed state, and how many states were consumed.
    logic [31:0] m_state [4];
    int          m_prev_c [4];
    int          m_count;
    logic [25:0] m_out [4];

    awgn_noise_gen #(
        .SEED0(S0), .SEED1(S1), .SEED2(S2), .SEED3(S3)
    ) dut (
        .CLK100MHZ (clk),
        .ck_rst    (rst),
        .i_enable  (enable),
        .i_reseed  (reseed),
        .i_sigma   (sigma),
        .o_noise1i (n1i),
        .o_noise1q (n1q),
        .o_noise2i (n2i),
        .o_noise2q (n2q),
        .o_valid   (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] ref_next(input logic [31:0] s);
        logic [31:0] r;
        if (s == 32'd0) return 32'd1;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic int ref_centred(input logic [31:0] s);
        return int'(s[7:0]) + int'(s[15:8]) + int'(s[23:16]) + int'(s[31:24]) - 510;
    endfunction

    task automatic model_seed();
        m_state[0] = (S0 == 0) ? 32'd1 : S0;
        m_state[1] = (S1 == 0) ? 32'd1 : S1;
        m_state[2] = (S2 == 0) ? 32'd1 : S2;
        m_state[3] = (S3 == 0) ? 32'd1 : S3;
        m_count = 0;
        for (int l = 0; l < 4; l++) begin
            m_prev_c[l] = 0;
            m_out[l]    = '0;
        end
    endtask

    task automatic model_enabled_edge(input logic [15:0] sig);
        for (int l = 0; l < 4; l++) begin
            if (m_count >= 1) m_out[l] = 26'(m_prev_c[l] * int'(sig));
            m_prev_c[l] = ref_centred(m_state[l]);
            m_state[l]  = ref_next(m_state[l]);
        end
        if (m_count < 2) m_count++;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".1i"}, {6'd0, n1i}, {6'd0, m_out[0]});
        check({tag, ".1q"}, {6'd0, n1q}, {6'd0, m_out[1]});
        check({tag, ".2i"}, {6'd0, n2i}, {6'd0, m_out[2]});
        check({tag, ".2q"}, {6'd0, n2q}, {6'd0, m_out[3]});
        check({tag, ".valid"}, {31'd0, valid}, {31'd0, (m_count >= 2)});
    endtask

    // Drive one clock with the given controls; inputs change 1 time unit after the edge.
    task automatic tick(input logic en, input logic rs);
        logic [15:0] sig_at_edge;
        enable = en;
        reseed = rs;
        sig_at_edge = sigma;
        @(posedge clk);
        #1;
        if (rs) model_seed();
        else if (en) model_enabled_edge(sig_at_edge);
    endtask

    initial begin
        real sum [4];
        real sumsq [4];
        real mean, sd, x;
        int  eq_pairs;
        logic [25:0] held;

        total = 0;
        bad = 0;
        rst = 1'b1;
        enable = 1'b0;
        reseed = 1'b0;
        sigma = 16'd0;
        model_seed();

        repeat (3) @(posedge clk);
        #5;
        rst = 1'b0;
        #1;
        check_all("reset");

        for (int i = 0; i < 10; i++) begin
            tick(1'b0, 1'b0);
            check_all("idle");
        end

        // Directed: first samples from each seed.
        sigma = 16'd4096;
        tick(1'b1, 1'b0);
        check_all("lat1");
        tick(1'b1, 1'b0);
        check_all("lat2");
        check("seed0_max", {6'd0, n1i}, 32'd2088960);
        check("valid_rise", {31'd0, valid}, 32'd1);

        sigma = 16'd65535;
        tick(1'b1, 1'b1);
        check_all("reseed_a");
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check_all("sig_max");
        check("seed1_min", {6'd0, n1q}, {6'd0, 26'(-33357315)});
        check("seed2_first", {6'd0, n2i}, 32'd131070);
        check("zero_seed_lane", {6'd0, n2q}, {6'd0, n1q});

        held = n2i;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0);
            check("hold", {6'd0, n2i}, {6'd0, held});
        end
        tick(1'b1, 1'b0);
        check_all("resume");

        // Randomised enable / sigma traffic with occasional reseed.
        for (int i = 0; i < 300; i++) begin
            sigma = 16'($urandom);
            tick(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
            check_all("rand");
        end

        sigma = 16'd0;
        for (int i = 0; i < 1000; i++) begin
            tick(1'b1, 1'b0);
            check_all("sig0");
        end
        check("sig0_zero", {6'd0, n1i | n1q | n2i | n2q}, 32'd0);

        // Statistics at unit sigma: std of the four-byte sum is sqrt(4*(256^2-1)/12)/128 ~ 1.155.
        sigma = 16'd4096;
        for (int l = 0; l < 4; l++) begin
            sum[l] = 0.0;
            sumsq[l] = 0.0;
        end
        eq_pairs = 0;
        tick(1'b1, 1'b0);
        for (int i = 0; i < N_STAT; i++) begin
            tick(1'b1, 1'b0);
            check_all("stat");
            for (int l = 0; l < 4; l++) begin
                x = $itor($signed(m_out[l])) / 524288.0;
                sum[l] += x;
                sumsq[l] += x * x;
            end
            if (n1i == n1q || n1i == n2i || n1q == n2i || n2i == n2q) eq_pairs++;
        end
        for (int l = 0; l < 4; l++) begin
            mean = sum[l] / N_STAT;
            sd = $sqrt(sumsq[l] / N_STAT - mean * mean);
            check($sformatf("mean%0d", l), {31'd0, (mean > -0.1 && mean < 0.1)}, 32'd1);
            check($sformatf("std%0d", l), {31'd0, (sd > 1.055 && sd < 1.255)}, 32'd1);
        end
        check("lanes_distinct", {31'd0, (eq_pairs < N_STAT / 100)}, 32'd1);

        // Reseed together with enable mid-stream: valid drops, sequence restarts.
        tick(1'b1, 1'b1);
        check_all("reseed_en");
        check("reseed_valid", {31'd0, valid}, 32'd0);
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check_all("reseed_first");
        check("reseed_seed0", {6'd0, n1i}, 32'd2088960);
        for (int i = 0; i < 20; i++) begin
            tick(1'b1, 1'b0);
            check_all("reseed_seq");
        end

        // Asynchronous reset between edges.
        #3;
        rst = 1'b1;
        #1;
        model_seed();
        check_all("async_rst");
        #1;
        rst = 1'b0;
        tick(1'b1, 1'b0);
        tick(1'b1, 1'b0);
        check_all("arst_first");
        check("arst_seed0", {6'd0, n1i}, 32'd2088960);
        for (int i = 0; i < 20; i++) begin
            sigma = 16'($urandom);
            tick(1'b1, 1'b0);
            check_all("arst_seq");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
